// File: rtl/avmm_stream_packer_if.sv
// Avalon-MM slave bus and Avalon-ST symbol source used by avmm_stream_packer.
// The slave modport is the packer's view; master is the host/sink side.
interface avmm_stream_packer_if #(
    parameter int AV_ADDRESS_W = 2,
    parameter int SYMBOL_W     = 8,
    parameter int NUMSYMBOLS   = 4
);
    localparam int AV_DATA_W = SYMBOL_W * NUMSYMBOLS;

    logic                    avs_write;
    logic                    avs_read;
    logic [AV_ADDRESS_W-1:0] avs_address;
    logic [NUMSYMBOLS-1:0]   avs_byteenable;
    logic [AV_DATA_W-1:0]    avs_writedata;
    logic [AV_DATA_W-1:0]    avs_readdata;
    logic                    avs_waitrequest;
    logic                    aso_valid;
    logic [SYMBOL_W-1:0]     aso_data;
    logic                    aso_ready;

    modport slave (
        input  avs_write, avs_read, avs_address, avs_byteenable, avs_writedata, aso_ready,
        output avs_readdata, avs_waitrequest, aso_valid, aso_data
    );

    modport master (
        output avs_write, avs_read, avs_address, avs_byteenable, avs_writedata, aso_ready,
        input  avs_readdata, avs_waitrequest, aso_valid, aso_data
    );
endinterface

// File: rtl/avmm_stream_packer.sv
// Avalon-MM register file plus word FIFO; each FIFO word is serialised one
// enabled symbol at a time onto an Avalon-ST ready/valid source.
module avmm_stream_packer #(
    parameter int AV_ADDRESS_W  = 2,
    parameter int SYMBOL_W      = 8,
    parameter int NUMSYMBOLS    = 4,
    parameter int FIFO_DEPTH    = 16,
    parameter int STALL_ON_FULL = 1,
    parameter int MSB_FIRST     = 0
) (
    input  logic                 clk,
    input  logic                 rstn,
    avmm_stream_packer_if.slave  bus
);
    localparam int AV_DATA_W = SYMBOL_W * NUMSYMBOLS;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int LVL_W     = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_e;

    state_e                state_q, state_d;
    logic [AV_DATA_W-1:0]  shift_q, shift_d;
    logic [NUMSYMBOLS-1:0] mask_q, mask_d;
    logic                  valid_q, valid_d;
    logic [SYMBOL_W-1:0]   sym_q, sym_d;
    logic                  enable_q, enable_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    logic [AV_DATA_W-1:0]  data_mem_q [FIFO_DEPTH];
    logic [NUMSYMBOLS-1:0] be_mem_q   [FIFO_DEPTH];

    logic [31:0] addr;
    logic        full;
    logic        empty;
    logic        wait_req;
    logic        wr_fire;
    logic        fire;
    logic        load;
    logic        pop;
    logic        push;
    logic        flush;
    logic [31:0] status;
    logic [31:0] rd_word;

    // Index of the symbol presented next for a given pending mask.
    function automatic int unsigned sym_index(input logic [NUMSYMBOLS-1:0] m);
        int unsigned idx = 0;
        for (int unsigned i = 0; i < NUMSYMBOLS; i++) begin
            if (MSB_FIRST != 0) begin
                if (m[i]) idx = i;
            end else if (m[NUMSYMBOLS-1-i]) begin
                idx = NUMSYMBOLS - 1 - i;
            end
        end
        return idx;
    endfunction

    function automatic logic [SYMBOL_W-1:0] sym_of(input logic [AV_DATA_W-1:0] w,
                                                   input logic [NUMSYMBOLS-1:0] m);
        return w[sym_index(m)*SYMBOL_W +: SYMBOL_W];
    endfunction

    assign addr     = 32'(bus.avs_address);
    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign wait_req = bus.avs_write && (addr == 32'd2) && full && (STALL_ON_FULL != 0);
    assign wr_fire  = bus.avs_write && !wait_req;
    assign fire     = valid_q && bus.aso_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        mask_d   = mask_q;
        enable_d = enable_q;
        ovf_d    = ovf_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        load     = 1'b0;
        pop      = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;

        case (state_q)
            S_IDLE: load = enable_q && !empty;
            S_EMIT: begin
                if (fire) begin
                    count_d = count_q + 32'd1;
                    mask_d  = mask_q & ~(NUMSYMBOLS'(1) << sym_index(mask_q));
                    if (mask_d == '0) begin
                        load = enable_q && !empty;
                        if (!load) state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A word with no enabled symbols is popped and dropped without leaving IDLE.
        if (load) begin
            pop     = 1'b1;
            shift_d = data_mem_q[rd_ptr_q];
            mask_d  = be_mem_q[rd_ptr_q];
            state_d = (mask_d != '0) ? S_EMIT : S_IDLE;
        end

        if (wr_fire) begin
            case (addr)
                32'd0: begin
                    enable_d = bus.avs_writedata[0];
                    flush    = bus.avs_writedata[1];
                    if (bus.avs_writedata[2]) ovf_d = 1'b0;
                end
                32'd2: begin
                    if (full) ovf_d = 1'b1;
                    else      push  = 1'b1;
                end
                32'd3:   count_d = '0;
                default: ;
            endcase
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: ;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            mask_d   = '0;
            state_d  = S_IDLE;
        end

        valid_d = (state_d == S_EMIT);
        sym_d   = valid_d ? sym_of(shift_d, mask_d) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            mask_q   <= '0;
            valid_q  <= 1'b0;
            sym_q    <= '0;
            enable_q <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            sym_q    <= sym_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= bus.avs_writedata;
            be_mem_q[wr_ptr_q]   <= bus.avs_byteenable;
        end
    end

    assign status = {12'd0, (state_q == S_EMIT), ovf_q, empty, full, 16'(level_q)};

    always_comb begin
        rd_word = '0;
        if (bus.avs_read) begin
            case (addr)
                32'd0:   rd_word[0] = enable_q;
                32'd1:   rd_word    = status;
                32'd3:   rd_word    = count_q;
                default: ;
            endcase
        end
        bus.avs_readdata = AV_DATA_W'(rd_word);
    end

    assign bus.avs_waitrequest = wait_req;
    assign bus.aso_valid       = valid_q;
    assign bus.aso_data        = sym_q;
endmodule

// File: tb/tb_avmm_stream_packer.sv
// Randomised bench for avmm_stream_packer: dut_a uses the default parameters,
// dut_b uses MSB-first order with drop-on-full. Symbols are scored against queues.
module tb_avmm_stream_packer;
    localparam int AW = 2;
    localparam int SW = 8;
    localparam int NS = 4;
    localparam int DW = SW * NS;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    avmm_stream_packer_if #(.AV_ADDRESS_W(AW), .SYMBOL_W(SW), .NUMSYMBOLS(NS)) bus_a ();
    avmm_stream_packer_if #(.AV_ADDRESS_W(AW), .SYMBOL_W(SW), .NUMSYMBOLS(NS)) bus_b ();

    avmm_stream_packer #(.AV_ADDRESS_W(AW), .SYMBOL_W(SW), .NUMSYMBOLS(NS), .FIFO_DEPTH(DEPTH),
                         .STALL_ON_FULL(1), .MSB_FIRST(0))
        dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
    avmm_stream_packer #(.AV_ADDRESS_W(AW), .SYMBOL_W(SW), .NUMSYMBOLS(NS), .FIFO_DEPTH(DEPTH),
                         .STALL_ON_FULL(0), .MSB_FIRST(1))
        dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_a[$];
    logic [SW-1:0] exp_b[$];
    int unsigned mcount[2];
    int rmode[2];
    bit stall_a = 0;
    bit stall_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic vld(input bit w);
        return w ? bus_b.aso_valid : bus_a.aso_valid;
    endfunction

    function automatic logic wreq(input bit w);
        return w ? bus_b.avs_waitrequest : bus_a.avs_waitrequest;
    endfunction

    task automatic drive(input bit w, input logic wr, input logic rd, input logic [AW-1:0] a,
                         input logic [NS-1:0] be, input logic [DW-1:0] d);
        if (w) begin
            bus_b.avs_write = wr; bus_b.avs_read = rd; bus_b.avs_address = a;
            bus_b.avs_byteenable = be; bus_b.avs_writedata = d;
        end else begin
            bus_a.avs_write = wr; bus_a.avs_read = rd; bus_a.avs_address = a;
            bus_a.avs_byteenable = be; bus_a.avs_writedata = d;
        end
    endtask

    // All bus tasks start and end just after a rising edge.
    task automatic mm_write(input bit w, input int addr, input logic [DW-1:0] d,
                            input logic [NS-1:0] be, output int stall);
        drive(w, 1'b1, 1'b0, AW'(addr), be, d);
        stall = 0;
        forever begin
            @(negedge clk);
            if (!wreq(w)) break;
            stall++;
            if (stall > 200) begin
                check("wreq_timeout", stall, 0);
                break;
            end
        end
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rd_check(input bit w, input int addr, input logic [31:0] exp, input string tag);
        drive(w, 1'b0, 1'b1, AW'(addr), '0, '0);
        @(negedge clk);
        check(tag, w ? bus_b.avs_readdata : bus_a.avs_readdata, exp);
        check("rd_no_wreq", wreq(w), 0);
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Reference: expand a word into its enabled symbols in the configured order.
    task automatic push_word(input bit w, input logic [DW-1:0] d, input logic [NS-1:0] be);
        for (int k = 0; k < NS; k++) begin
            int i;
            i = w ? (NS - 1 - k) : k;
            if (be[i]) begin
                if (w) exp_b.push_back(d[i*SW +: SW]);
                else   exp_a.push_back(d[i*SW +: SW]);
                mcount[w] = mcount[w] + 1;
            end
        end
    endtask

    task automatic data_write(input bit w, input logic [DW-1:0] d, input logic [NS-1:0] be);
        int st;
        mm_write(w, 2, d, be, st);
        push_word(w, d, be);
    endtask

    task automatic set_ctrl(input bit w, input logic [2:0] v);
        int st;
        mm_write(w, 0, DW'(v), '0, st);
        if (v[1]) begin
            if (w) begin
                mcount[1] = mcount[1] - exp_b.size(); exp_b.delete(); stall_b = 0;
            end else begin
                mcount[0] = mcount[0] - exp_a.size(); exp_a.delete(); stall_a = 0;
            end
        end
    endtask

    task automatic clr_count(input bit w);
        int st;
        mm_write(w, 3, '0, '0, st);
        mcount[w] = 0;
    endtask

    task automatic wait_valid(input bit w);
        int n = 0;
        @(negedge clk);
        while (!vld(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", vld(w), 1);
    endtask

    task automatic drain(input bit w);
        int n = 0;
        while ((w ? exp_b.size() : exp_a.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(w ? "b_drain" : "a_drain", w ? exp_b.size() : exp_a.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_a) check("a_hold_valid", bus_a.aso_valid, 1);
            if (bus_a.aso_valid) begin
                if (exp_a.size() == 0) check("a_unexpected_sym", exp_a.size(), 1);
                else begin
                    check("a_sym", bus_a.aso_data, exp_a[0]);
                    if (bus_a.aso_ready) void'(exp_a.pop_front());
                end
            end
            stall_a = bus_a.aso_valid && !bus_a.aso_ready;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (stall_b) check("b_hold_valid", bus_b.aso_valid, 1);
            if (bus_b.aso_valid) begin
                if (exp_b.size() == 0) check("b_unexpected_sym", exp_b.size(), 1);
                else begin
                    check("b_sym", bus_b.aso_data, exp_b[0]);
                    if (bus_b.aso_ready) void'(exp_b.pop_front());
                end
            end
            stall_b = bus_b.aso_valid && !bus_b.aso_ready;
        end
    end

    // Ready modes: 0 always, 1 pattern 1,0,0, 2 random, 3 never, 4 driven by hand.
    initial begin
        int k = 0;
        bus_a.aso_ready = 1'b0;
        bus_b.aso_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            k++;
            case (rmode[0])
                0: bus_a.aso_ready = 1'b1;
                1: bus_a.aso_ready = (k % 3 == 0);
                2: bus_a.aso_ready = 1'($urandom_range(0, 1));
                3: bus_a.aso_ready = 1'b0;
                default: ;
            endcase
            case (rmode[1])
                0: bus_b.aso_ready = 1'b1;
                1: bus_b.aso_ready = (k % 3 == 0);
                2: bus_b.aso_ready = 1'($urandom_range(0, 1));
                3: bus_b.aso_ready = 1'b0;
                default: ;
            endcase
        end
    end

    initial begin
        int st;
        int first;
        int last;
        int nv;
        logic [DW-1:0] words[17];

        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
        mcount[0] = 0; mcount[1] = 0;
        rmode[0] = 0; rmode[1] = 0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Reset state
        @(negedge clk);
        check("a_rst_valid", bus_a.aso_valid, 0);
        check("a_rst_wreq", bus_a.avs_waitrequest, 0);
        @(posedge clk); #1;
        rd_check(0, 0, 32'h0, "a_rst_ctrl");
        rd_check(0, 1, 32'h0002_0000, "a_rst_status");
        rd_check(0, 3, 32'h0, "a_rst_count");
        rd_check(0, 2, 32'h0, "a_data_reads0");

        set_ctrl(0, 3'b001);
        rd_check(0, 0, 32'h1, "a_ctrl_en");
        @(negedge clk);
        check("a_rdata_idle", bus_a.avs_readdata, 0);
        @(posedge clk); #1;

        // Basic word with latency check
        data_write(0, 32'h4433_2211, 4'hF);
        @(negedge clk);
        check("a_lat_e0", bus_a.aso_valid, 0);
        @(negedge clk);
        check("a_lat_e1", bus_a.aso_valid, 1);
        check("a_first_sym", bus_a.aso_data, 32'h11);
        @(posedge clk); #1;
        drain(0);
        rd_check(0, 3, mcount[0], "a_count_basic");
        rd_check(0, 1, 32'h0002_0000, "a_status_empty");

        // Masking
        data_write(0, 32'h4433_2211, 4'hA);
        drain(0);
        data_write(0, 32'h4433_2211, 4'h0);
        repeat (5) @(negedge clk);
        check("a_be0_novalid", bus_a.aso_valid, 0);
        @(posedge clk); #1;
        rd_check(0, 3, mcount[0], "a_count_mask");

        // Throughput: three full words queued, then enabled
        set_ctrl(0, 3'b000);
        for (int i = 0; i < 3; i++) data_write(0, $urandom, 4'hF);
        set_ctrl(0, 3'b001);
        first = -1; last = -1; nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_a.aso_valid) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
        end
        check("a_tput_count", nv, 12);
        check("a_tput_span", last - first + 1, 12);
        @(posedge clk); #1;
        drain(0);

        // Backpressure 1,0,0
        clr_count(0);
        rmode[0] = 1;
        for (int i = 0; i < 3; i++) data_write(0, $urandom, 4'hF);
        drain(0);
        rd_check(0, 3, 32'd12, "a_count_bp");

        // Random traffic
        rmode[0] = 2;
        for (int i = 0; i < 40; i++) begin
            data_write(0, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        drain(0);
        rd_check(0, 3, mcount[0], "a_count_rand");

        // Full / stall
        rmode[0] = 0;
        set_ctrl(0, 3'b000);
        for (int i = 0; i < 17; i++) words[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) data_write(0, words[i], 4'hF);
        rd_check(0, 1, 32'h0001_0010, "a_status_full");
        drive(0, 1'b1, 1'b0, AW'(2), 4'hF, words[16]);
        repeat (3) @(negedge clk);
        check("a_stall_wreq", bus_a.avs_waitrequest, 1);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0, '0);
        rd_check(0, 1, 32'h0001_0010, "a_status_still_full");
        set_ctrl(0, 3'b001);
        data_write(0, words[16], 4'hF);
        drain(0);
        rd_check(0, 3, mcount[0], "a_count_full");

        // Flush mid-word
        rmode[0] = 3;
        set_ctrl(0, 3'b000);
        clr_count(0);
        for (int i = 0; i < 3; i++) data_write(0, $urandom, 4'hF);
        set_ctrl(0, 3'b001);
        wait_valid(0);
        rmode[0] = 4;
        @(posedge clk); #1;
        bus_a.aso_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus_a.aso_ready = 1'b0;
        set_ctrl(0, 3'b011);
        @(negedge clk);
        check("a_flush_valid", bus_a.aso_valid, 0);
        @(posedge clk); #1;
        rd_check(0, 1, 32'h0002_0000, "a_flush_status");
        rd_check(0, 3, 32'd2, "a_flush_count");
        check("a_flush_model", mcount[0], 2);

        // Reset mid-stream
        rmode[0] = 3;
        data_write(0, 32'hA5B6_C7D8, 4'hF);
        wait_valid(0);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        check("a_rst_mid_valid", bus_a.aso_valid, 0);
        exp_a.delete(); exp_b.delete();
        mcount[0] = 0; mcount[1] = 0;
        stall_a = 0; stall_b = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        rd_check(0, 0, 32'h0, "a_post_rst_ctrl");
        rd_check(0, 1, 32'h0002_0000, "a_post_rst_status");
        rd_check(0, 3, 32'h0, "a_post_rst_count");
        rmode[0] = 0;
        set_ctrl(0, 3'b001);
        data_write(0, 32'h0102_0304, 4'hF);
        drain(0);
        rd_check(0, 3, 32'd4, "a_post_rst_stream");

        // MSB-first, drop-on-full instance
        rmode[1] = 0;
        set_ctrl(1, 3'b001);
        data_write(1, 32'h4433_2211, 4'hA);
        wait_valid(1);
        check("b_first_msb", bus_b.aso_data, 32'h44);
        @(posedge clk); #1;
        drain(1);
        data_write(1, 32'h4433_2211, 4'hF);
        drain(1);
        rd_check(1, 3, 32'd6, "b_count");
        set_ctrl(1, 3'b000);
        for (int i = 0; i < DEPTH; i++) data_write(1, $urandom, 4'($urandom_range(0, 15)));
        rd_check(1, 1, 32'h0001_0010, "b_status_full");
        mm_write(1, 2, 32'hDEAD_BEEF, 4'hF, st);
        check("b_no_stall", st, 0);
        rd_check(1, 1, 32'h0005_0010, "b_status_ovf");
        set_ctrl(1, 3'b100);
        rd_check(1, 1, 32'h0001_0010, "b_ovf_clear");
        rmode[1] = 2;
        set_ctrl(1, 3'b001);
        drain(1);
        rd_check(1, 3, mcount[1], "b_count_drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got %0d checks expected completion", checks);
        $fatal(1);
    end
endmodule
